// File: rtl/text_overlay_pkg.sv
// Shared definitions for the end-of-game text overlay: glyph codes, message
// strings and overlay geometry.
package text_overlay_pkg;

  typedef enum logic [3:0] {
    GLYPH_SPACE = 4'd0,
    GLYPH_Y     = 4'd1,
    GLYPH_O     = 4'd2,
    GLYPH_U     = 4'd3,
    GLYPH_W     = 4'd4,
    GLYPH_I     = 4'd5,
    GLYPH_N     = 4'd6,
    GLYPH_L     = 4'd7,
    GLYPH_S     = 4'd8,
    GLYPH_E     = 4'd9
  } glyph_e;

  localparam int unsigned H_SCALE_DEF  = 10;
  localparam int unsigned V_SCALE_DEF  = 5;
  localparam int unsigned OVERLAY_CELL = 80;

  typedef glyph_e msg_t [8];

  localparam msg_t MSG_WIN  = '{GLYPH_Y, GLYPH_O, GLYPH_U, GLYPH_SPACE,
                                GLYPH_W, GLYPH_I, GLYPH_N, GLYPH_SPACE};
  localparam msg_t MSG_LOSE = '{GLYPH_Y, GLYPH_O, GLYPH_U, GLYPH_SPACE,
                                GLYPH_L, GLYPH_O, GLYPH_S, GLYPH_E};

  localparam logic [3:0] MSG_WIN_LEN  = 4'd7;
  localparam logic [3:0] MSG_LOSE_LEN = 4'd8;

  // Column beyond the selected message's length resolves to space.
  function automatic glyph_e msg_char(input logic sel, input logic [3:0] col);
    glyph_e g;
    g = GLYPH_SPACE;
    if (!sel) begin
      if (col < MSG_WIN_LEN) g = MSG_WIN[col[2:0]];
    end else begin
      if (col < MSG_LOSE_LEN) g = MSG_LOSE[col[2:0]];
    end
    return g;
  endfunction

endpackage

// File: rtl/font_rom_8x16.sv
// Synchronous 8x16 glyph ROM; row 0 sits in the most significant byte and
// font bit 7 is the leftmost pixel.
module font_rom_8x16
  import text_overlay_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  glyph_e     code_i,
  input  logic [3:0] row_i,
  output logic [7:0] row_o
);

  logic [127:0] glyph;

  always_comb begin
    glyph = '0;
    case (code_i)
      GLYPH_Y: glyph = 128'hC3C3_6666_3C3C_1818_1818_1818_1818_0000;
      GLYPH_O: glyph = 128'h3C66_C3C3_C3C3_C3C3_C3C3_C3C3_663C_0000;
      GLYPH_U: glyph = 128'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3_663C_0000;
      GLYPH_W: glyph = 128'hC3C3_C3C3_C3C3_C3C3_DBDB_FFFF_E7C3_0000;
      GLYPH_I: glyph = 128'h7E18_1818_1818_1818_1818_1818_187E_0000;
      GLYPH_N: glyph = 128'hC3E3_E3F3_F3DB_DBCF_CFC7_C7C3_C3C3_0000;
      GLYPH_L: glyph = 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0FF_0000;
      GLYPH_S: glyph = 128'h7EC3_C0C0_603C_0603_0303_03C3_C37E_0000;
      GLYPH_E: glyph = 128'hFFC0_C0C0_C0C0_FEC0_C0C0_C0C0_C0FF_0000;
      default: glyph = '0;
    endcase
  end

  // {~row, 3'b000} == 8*(15-row): row 0 is the top byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) row_o <= '0;
    else       row_o <= glyph[{~row_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/you_win_text_rom.sv
// End-of-game overlay glyph responder: cell/line request in, scaled 80-pixel
// row out two pclk cycles later, with per-frame message latch and blink.
module you_win_text_rom
  import text_overlay_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned H_SCALE      = H_SCALE_DEF,
  parameter int unsigned V_SCALE      = V_SCALE_DEF
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [7:0]              char_yx_in,
  input  logic [7:0]              char_line_in,
  input  logic                    vsync_in,
  input  logic                    msg_sel_in,
  input  logic                    blink_en_in,
  output logic [OVERLAY_CELL-1:0] char_pixels_out
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(BLINK_FRAMES - 1);
  localparam logic [7:0]    LINE_LIMIT = 8'(OVERLAY_CELL);

  logic          vsync_d_q;
  logic          vsync_rise;
  logic          msg_q, msg_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          visible_q, visible_d;

  glyph_e        code_q, code_d;
  logic [3:0]    row_q, row_d;
  logic          oor_q, oor_d;
  logic          vis_s1_q;

  glyph_e        rom_code;
  logic [7:0]    rom_row;

  assign vsync_rise = vsync_in & ~vsync_d_q;

  always_comb begin
    msg_d       = msg_q;
    frame_cnt_d = frame_cnt_q;
    visible_d   = visible_q;
    if (vsync_rise) msg_d = msg_sel_in;
    if (!blink_en_in) begin
      frame_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (vsync_rise) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    code_d = GLYPH_SPACE;
    if (char_yx_in[7:4] == 4'd0) code_d = msg_char(msg_q, char_yx_in[3:0]);
    row_d = 4'(char_line_in / V_SCALE);
    oor_d = (char_line_in >= LINE_LIMIT);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_d_q   <= 1'b0;
      msg_q       <= 1'b0;
      frame_cnt_q <= '0;
      visible_q   <= 1'b1;
      code_q      <= GLYPH_SPACE;
      row_q       <= '0;
      oor_q       <= 1'b0;
      vis_s1_q    <= 1'b0;
    end else begin
      vsync_d_q   <= vsync_in;
      msg_q       <= msg_d;
      frame_cnt_q <= frame_cnt_d;
      visible_q   <= visible_d;
      code_q      <= code_d;
      row_q       <= row_d;
      oor_q       <= oor_d;
      vis_s1_q    <= visible_q;
    end
  end

  // Blanking is folded into the ROM address so the output stays a pure
  // re-wiring of the ROM register, keeping latency at two cycles.
  assign rom_code = (oor_q || !vis_s1_q) ? GLYPH_SPACE : code_q;

  font_rom_8x16 u_font_rom (
    .clk_i (pclk),
    .rst_i (rst),
    .code_i(rom_code),
    .row_i (row_q),
    .row_o (rom_row)
  );

  // Output bit i shows scaled column 80-i; column 0 has no bit, bit 0 is tied low.
  assign char_pixels_out[0] = 1'b0;
  for (genvar i = 1; i < OVERLAY_CELL; i++) begin : g_expand
    assign char_pixels_out[i] = rom_row[7 - (OVERLAY_CELL - i) / H_SCALE];
  end

endmodule

// File: tb/tb_you_win_text_rom.sv
// Directed plus randomized check of you_win_text_rom against a string/font
// reference model with blink expressed as vsync-edge arithmetic.
module tb_you_win_text_rom;

  localparam int BF = 2;

  logic        pclk;
  logic        rst;
  logic [7:0]  char_yx_in;
  logic [7:0]  char_line_in;
  logic        vsync_in;
  logic        msg_sel_in;
  logic        blink_en_in;
  logic [79:0] char_pixels_out;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_msg   = 0;
  bit          m_vprev = 0;
  int          m_edges = 0;
  logic [79:0] m_s1    = '0;
  logic [79:0] m_out   = '0;

  you_win_text_rom #(
    .BLINK_FRAMES(BF),
    .H_SCALE     (10),
    .V_SCALE     (5)
  ) dut (
    .pclk           (pclk),
    .rst            (rst),
    .char_yx_in     (char_yx_in),
    .char_line_in   (char_line_in),
    .vsync_in       (vsync_in),
    .msg_sel_in     (msg_sel_in),
    .blink_en_in    (blink_en_in),
    .char_pixels_out(char_pixels_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [7:0] font_byte(input byte ch, input int row);
    logic [127:0] g;
    case (ch)
      "Y": g = 128'hC3C3_6666_3C3C_1818_1818_1818_1818_0000;
      "O": g = 128'h3C66_C3C3_C3C3_C3C3_C3C3_C3C3_663C_0000;
      "U": g = 128'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3_663C_0000;
      "W": g = 128'hC3C3_C3C3_C3C3_C3C3_DBDB_FFFF_E7C3_0000;
      "I": g = 128'h7E18_1818_1818_1818_1818_1818_187E_0000;
      "N": g = 128'hC3E3_E3F3_F3DB_DBCF_CFC7_C7C3_C3C3_0000;
      "L": g = 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0FF_0000;
      "S": g = 128'h7EC3_C0C0_603C_0603_0303_03C3_C37E_0000;
      "E": g = 128'hFFC0_C0C0_C0C0_FEC0_C0C0_C0C0_C0FF_0000;
      default: g = '0;
    endcase
    return g[127 - 8*row -: 8];
  endfunction

  function automatic logic [79:0] ref_row(input bit m, input logic [7:0] yx,
                                          input logic [7:0] line, input bit vis);
    string       s;
    int          k;
    logic [7:0]  fb;
    logic [79:0] r;
    r = '0;
    if (!vis || line >= 80 || yx[7:4] != 4'd0) return r;
    s = m ? "YOU LOSE" : "YOU WIN";
    k = int'(yx[3:0]);
    if (k >= s.len()) return r;
    fb = font_byte(s[k], int'(line) / 5);
    for (int c = 1; c < 80; c++) r[80 - c] = fb[7 - c / 10];
    return r;
  endfunction

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [79:0] r;
    bit          rise;
    r = ref_row(m_msg, char_yx_in, char_line_in, ((m_edges / BF) % 2) == 0);
    @(posedge pclk);
    m_out = rst ? '0 : m_s1;
    m_s1  = rst ? '0 : r;
    if (rst) begin
      m_msg = 0; m_vprev = 0; m_edges = 0;
    end else begin
      rise = vsync_in && !m_vprev;
      if (rise) m_msg = msg_sel_in;
      if (!blink_en_in) m_edges = 0;
      else if (rise) m_edges++;
      m_vprev = vsync_in;
    end
    #1;
    check(tag, char_pixels_out, m_out);
  endtask

  task automatic vpulse(input string tag);
    vsync_in = 1'b1; tick(tag);
    vsync_in = 1'b0; tick(tag);
  endtask

  initial begin
    rst = 1'b1; char_yx_in = 8'h00; char_line_in = 8'd0;
    vsync_in = 1'b0; msg_sel_in = 1'b0; blink_en_in = 1'b0;
    tick("reset"); tick("reset");

    rst = 1'b0;
    repeat (3) tick("y_row0");

    char_line_in = 8'd25;
    for (int k = 0; k < 8; k++) begin
      char_yx_in = 8'(k);
      tick("stream");
      check("bit0", {79'b0, char_pixels_out[0]}, '0);
    end
    repeat (2) begin
      tick("stream_tail");
      check("bit0", {79'b0, char_pixels_out[0]}, '0);
    end

    char_yx_in = 8'h10; char_line_in = 8'd10; tick("oor_row");
    char_yx_in = 8'h00; char_line_in = 8'd80; tick("oor_line");
    char_line_in = 8'd79; tick("last_line");
    char_line_in = 8'd255; repeat (3) tick("oor_line");

    char_yx_in = 8'h04; char_line_in = 8'd10; msg_sel_in = 1'b1;
    repeat (3) tick("msg_before");
    vpulse("msg_edge");
    repeat (3) tick("msg_after");

    blink_en_in = 1'b1; char_yx_in = 8'h00; char_line_in = 8'd30;
    repeat (2) tick("blink_on");
    repeat (2) vpulse("blink_e12");
    repeat (3) tick("blink_dark");
    repeat (2) vpulse("blink_e34");
    repeat (3) tick("blink_back");
    repeat (2) vpulse("blink_e56");
    repeat (2) tick("blink_dark2");
    blink_en_in = 1'b0;
    repeat (4) tick("blink_off");

    vsync_in = 1'b1; blink_en_in = 1'b1; tick("vs_en");
    vsync_in = 1'b0; tick("vs_en");
    vsync_in = 1'b1; blink_en_in = 1'b0; tick("vs_clear");
    vsync_in = 1'b0; repeat (3) tick("vs_clear");

    char_line_in = 8'd40;
    for (int k = 0; k < 8; k++) begin
      char_yx_in = 8'(k);
      rst = (k == 3);
      tick("rst_stream");
    end
    rst = 1'b0; char_yx_in = 8'h04;
    repeat (4) tick("rst_msg");

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       char_yx_in = 8'($urandom_range(0, 8));
        1:       char_yx_in = 8'($urandom_range(0, 255));
        default: char_yx_in = 8'($urandom_range(0, 7));
      endcase
      char_line_in = 8'($urandom_range(0, 90));
      msg_sel_in   = 1'($urandom_range(0, 1));
      vsync_in     = ((n % 17) < 2) || ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 40) == 0) blink_en_in = ~blink_en_in;
      rst          = ($urandom_range(0, 80) == 0);
      tick("random");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
